// File: rtl/seq_memory_game.sv
// Sequence-memory game engine: plays back a growing prefix of a loaded note
// sequence on tone/led, then checks the player's keypad answers in forward or
// reverse order, with a configurable number of lives.
module seq_memory_game #(
   parameter int unsigned NOTE_W    = 3,
   parameter int unsigned MAX_LEN   = 8,
   parameter int unsigned TICK_DIV  = 4,
   parameter int unsigned ON_TICKS  = 2,
   parameter int unsigned OFF_TICKS = 2,
   parameter int unsigned LIVES     = 3,
   parameter int unsigned REVERSE   = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               load,
   input  logic [MAX_LEN*NOTE_W-1:0]          seq_data,
   input  logic                               start,
   input  logic                               key_valid,
   input  logic [NOTE_W:0]                    key_code,
   output logic [NOTE_W:0]                    tone,
   output logic [NOTE_W:0]                    led,
   output logic                               playing,
   output logic                               await_input,
   output logic [$clog2(MAX_LEN+1)-1:0]       round_len,
   output logic [$clog2(LIVES+1)-1:0]         lives_left,
   output logic                               miss,
   output logic                               win,
   output logic                               lose
);

   localparam int unsigned IW      = $clog2(MAX_LEN + 1);
   localparam int unsigned LW      = $clog2(LIVES + 1);
   localparam int unsigned TW      = NOTE_W + 1;
   localparam int unsigned SEQ_W   = MAX_LEN * NOTE_W;
   localparam int unsigned ON_CYC  = ON_TICKS * TICK_DIV;
   localparam int unsigned OFF_CYC = OFF_TICKS * TICK_DIV;
   localparam int unsigned CNT_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAY_ON,
      S_PLAY_OFF,
      S_WAIT_KEY,
      S_ECHO,
      S_WIN,
      S_LOSE
   } state_t;

   state_t          r_state,    w_state_nxt;
   logic [CW-1:0]   r_cnt,      w_cnt_nxt;
   logic            r_loaded,   w_loaded_nxt;
   logic [SEQ_W-1:0] r_seq,     w_seq_nxt;
   logic [IW-1:0]   r_round,    w_round_nxt;
   logic [IW-1:0]   r_play_idx, w_play_nxt;
   logic [IW-1:0]   r_exp_idx,  w_exp_nxt;
   logic [IW-1:0]   r_resp_cnt, w_resp_nxt;
   logic [LW-1:0]   r_lives,    w_lives_nxt;
   logic            r_correct,  w_correct_nxt;
   logic            r_last,     w_last_nxt;
   logic [TW-1:0]   r_tone,     w_tone_nxt;
   logic [TW-1:0]   r_led;
   logic            r_miss,     w_miss_nxt;
   logic            r_playing;
   logic            r_await;
   logic            r_win;
   logic            r_lose;

   logic            w_on_done;
   logic            w_off_done;

   // Tone code of stored note idx; the +1 is done at NOTE_W+1 bits so the
   // top note value does not wrap to silence.
   function automatic logic [TW-1:0] tone_of(input logic [SEQ_W-1:0] seq,
                                             input logic [IW-1:0]    idx);
      logic [TW-1:0] t;
      t = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (idx == IW'(i)) begin
            t = {1'b0, seq[i*NOTE_W +: NOTE_W]} + TW'(1);
         end
      end
      return t;
   endfunction

   assign w_on_done  = (r_cnt == CW'(ON_CYC - 1));
   assign w_off_done = (r_cnt == CW'(OFF_CYC - 1));

   // Next-state and next-register computation for the whole game.
   always_comb begin
      w_state_nxt   = r_state;
      w_loaded_nxt  = r_loaded;
      w_seq_nxt     = r_seq;
      w_round_nxt   = r_round;
      w_lives_nxt   = r_lives;
      w_play_nxt    = r_play_idx;
      w_exp_nxt     = r_exp_idx;
      w_resp_nxt    = r_resp_cnt;
      w_correct_nxt = r_correct;
      w_last_nxt    = r_last;
      w_tone_nxt    = '0;
      w_miss_nxt    = 1'b0;
      w_cnt_nxt     = '0;

      case (r_state)
         S_IDLE, S_WIN, S_LOSE: begin
            if (load) begin
               w_seq_nxt    = seq_data;
               w_loaded_nxt = 1'b1;
            end
            // A same-cycle load counts as loaded and its data is played.
            if (start && (r_loaded || load)) begin
               w_state_nxt = S_PLAY_ON;
               w_round_nxt = IW'(1);
               w_lives_nxt = LW'(LIVES);
               w_play_nxt  = '0;
               w_exp_nxt   = '0;
               w_resp_nxt  = '0;
               w_tone_nxt  = tone_of(w_seq_nxt, IW'(0));
            end
         end

         S_PLAY_ON: begin
            if (w_on_done) begin
               w_state_nxt = S_PLAY_OFF;
            end else begin
               w_tone_nxt = r_tone;
            end
         end

         S_PLAY_OFF: begin
            if (w_off_done) begin
               if (r_play_idx == r_round - IW'(1)) begin
                  w_state_nxt = S_WAIT_KEY;
                  w_exp_nxt   = (REVERSE != 0) ? r_round - IW'(1) : '0;
                  w_resp_nxt  = '0;
               end else begin
                  w_state_nxt = S_PLAY_ON;
                  w_play_nxt  = r_play_idx + IW'(1);
                  w_tone_nxt  = tone_of(r_seq, r_play_idx + IW'(1));
               end
            end
         end

         S_WAIT_KEY: begin
            if (key_valid && (key_code != '0)) begin
               w_state_nxt   = S_ECHO;
               w_tone_nxt    = key_code;
               w_correct_nxt = (key_code == tone_of(r_seq, r_exp_idx));
               w_last_nxt    = (r_resp_cnt == r_round - IW'(1));
               w_resp_nxt    = r_resp_cnt + IW'(1);
               // Penalty is applied at acceptance; ECHO only decides where to go.
               if (!w_correct_nxt) begin
                  w_miss_nxt  = 1'b1;
                  w_lives_nxt = r_lives - LW'(1);
               end
            end
         end

         S_ECHO: begin
            if (!w_on_done) begin
               w_tone_nxt = r_tone;
            end else if (r_correct) begin
               if (!r_last) begin
                  w_state_nxt = S_WAIT_KEY;
                  w_exp_nxt   = (REVERSE != 0) ? r_exp_idx - IW'(1)
                                               : r_exp_idx + IW'(1);
               end else if (r_round == IW'(MAX_LEN)) begin
                  w_state_nxt = S_WIN;
               end else begin
                  w_state_nxt = S_PLAY_ON;
                  w_round_nxt = r_round + IW'(1);
                  w_play_nxt  = '0;
                  w_tone_nxt  = tone_of(r_seq, IW'(0));
               end
            end else if (r_lives == '0) begin
               w_state_nxt = S_LOSE;
            end else begin
               w_state_nxt = S_PLAY_ON;
               w_play_nxt  = '0;
               w_tone_nxt  = tone_of(r_seq, IW'(0));
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Tempo counter only advances while staying in a timed state.
      if ((w_state_nxt == r_state) &&
          ((r_state == S_PLAY_ON) || (r_state == S_PLAY_OFF) || (r_state == S_ECHO))) begin
         w_cnt_nxt = r_cnt + CW'(1);
      end
   end

   // State and registered outputs; async reset silences everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_loaded   <= 1'b0;
         r_seq      <= '0;
         r_round    <= '0;
         r_play_idx <= '0;
         r_exp_idx  <= '0;
         r_resp_cnt <= '0;
         r_lives    <= '0;
         r_correct  <= 1'b0;
         r_last     <= 1'b0;
         r_tone     <= '0;
         r_led      <= '0;
         r_miss     <= 1'b0;
         r_playing  <= 1'b0;
         r_await    <= 1'b0;
         r_win      <= 1'b0;
         r_lose     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_loaded   <= w_loaded_nxt;
         r_seq      <= w_seq_nxt;
         r_round    <= w_round_nxt;
         r_play_idx <= w_play_nxt;
         r_exp_idx  <= w_exp_nxt;
         r_resp_cnt <= w_resp_nxt;
         r_lives    <= w_lives_nxt;
         r_correct  <= w_correct_nxt;
         r_last     <= w_last_nxt;
         r_tone     <= w_tone_nxt;
         r_led      <= w_tone_nxt;
         r_miss     <= w_miss_nxt;
         r_playing  <= (w_state_nxt == S_PLAY_ON) || (w_state_nxt == S_PLAY_OFF);
         r_await    <= (w_state_nxt == S_WAIT_KEY);
         r_win      <= (w_state_nxt == S_WIN);
         r_lose     <= (w_state_nxt == S_LOSE);
      end
   end

   assign tone        = r_tone;
   assign led         = r_led;
   assign playing     = r_playing;
   assign await_input = r_await;
   assign round_len   = r_round;
   assign lives_left  = r_lives;
   assign miss        = r_miss;
   assign win         = r_win;
   assign lose        = r_lose;

endmodule
